// File: rtl/mac_pkg.sv
// Shared state encoding and line levels for the MAC receive deframer.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } mac_state_e;

  localparam logic MAC_IDLE_LEVEL  = 1'b1;
  localparam logic MAC_START_LEVEL = 1'b0;
  localparam logic MAC_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/mac_rx_fifo.sv
// Show-ahead received-byte buffer; a pop in the same cycle frees room for a push into a full FIFO.
module mac_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(FIFO_DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mac_rx_deframer.sv
// Serial receive deframer: synchronizes mac_rx, validates start/stop framing and buffers bytes.
// Optional even-parity checking is built when MAC_RX_PARITY_EN is defined.
module mac_rx_deframer
  import mac_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mac_rx,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_busy,
  output logic                        frame_err,
  output logic                        overflow,
`ifdef MAC_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_C     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST_C = BIT_W'(DATA_W - 1);

  mac_state_e        state_r, state_next;
  logic              rx_meta_r, rx_s;
  logic [CNT_W-1:0]  clk_cnt_r, clk_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_next;
  logic [DATA_W-1:0] shift_r, shift_next;
  logic              push_s, pop_s, empty_s, full_s;
  logic              frame_err_r, frame_err_next;
  logic              overflow_r, overflow_next;
  logic              busy_r;
`ifdef MAC_RX_PARITY_EN
  logic              par_bad_r, par_bad_next;
  logic              parity_err_r, parity_err_next;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign parity_err = parity_err_r;
`endif

  assign pop_s         = !empty_s && rx_ready;
  assign rx_valid      = !empty_s;
  assign rx_busy       = busy_r;
  assign frame_err     = frame_err_r;
  assign overflow      = overflow_r;
  assign overflow_next = push_s && full_s && !pop_s;

  // Two-flop synchronizer; idles at the line's idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= MAC_IDLE_LEVEL;
      rx_s      <= MAC_IDLE_LEVEL;
    end else begin
      rx_meta_r <= mac_rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Frame FSM next-state; counters restart on every state entry.
  always_comb begin
    state_next     = state_r;
    clk_cnt_next   = clk_cnt_r + CNT_W'(1);
    bit_cnt_next   = bit_cnt_r;
    shift_next     = shift_r;
    push_s         = 1'b0;
    frame_err_next = 1'b0;
`ifdef MAC_RX_PARITY_EN
    par_bad_next    = par_bad_r;
    parity_err_next = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (rx_s == MAC_START_LEVEL) state_next = START;
        else                         state_next = IDLE;
      end
      START: begin
        if (clk_cnt_r == HALF_C) begin
          clk_cnt_next = '0;
          // A line already back high at mid-start is treated as noise.
          if (rx_s == MAC_START_LEVEL) state_next = DATA;
          else                         state_next = IDLE;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (clk_cnt_r == LAST_C) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s, shift_r[DATA_W-1:1]};
          if (bit_cnt_r == BIT_LAST_C) begin
            bit_cnt_next = '0;
`ifdef MAC_RX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_next = DATA;
        end
      end
`ifdef MAC_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_r == LAST_C) begin
          clk_cnt_next = '0;
          par_bad_next = (rx_s != even_parity(shift_r));
          state_next   = STOP;
        end else begin
          state_next = PARITY;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_r == LAST_C) begin
          clk_cnt_next = '0;
          if (rx_s == MAC_STOP_LEVEL) begin
            state_next = IDLE;
`ifdef MAC_RX_PARITY_EN
            if (par_bad_r) parity_err_next = 1'b1;
            else           push_s          = 1'b1;
`else
            push_s     = 1'b1;
`endif
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          state_next = STOP;
        end
      end
      BREAK: begin
        clk_cnt_next = '0;
        if (rx_s == MAC_IDLE_LEVEL) state_next = IDLE;
        else                        state_next = BREAK;
      end
      default: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  // FSM state, datapath and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      clk_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
`ifdef MAC_RX_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_next;
      clk_cnt_r   <= clk_cnt_next;
      bit_cnt_r   <= bit_cnt_next;
      shift_r     <= shift_next;
      frame_err_r <= frame_err_next;
      overflow_r  <= overflow_next;
      busy_r      <= (state_next != IDLE);
`ifdef MAC_RX_PARITY_EN
      par_bad_r    <= par_bad_next;
      parity_err_r <= parity_err_next;
`endif
    end
  end

  mac_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (pop_s),
    .head_data (rx_data),
    .empty     (empty_s),
    .full      (full_s),
    .count     (fifo_count)
  );

endmodule
